// File: rtl/mag_spec_integrator.sv
// mag_spec_integrator: integrates cfg_int_len consecutive magnitude spectra
// per channel in a channel-indexed accumulator RAM and emits one integrated
// spectrum per integration period, one cycle after the last input sample.
// Optional build macro: MAG_INTEG_SAT_EN -- saturating accumulate with a
// sticky overflow flag; without it the accumulate wraps and ovf_sticky is 0.
module mag_spec_integrator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_CHAN   = 256,
    parameter int CHAN_W     = 8
) (
    input  logic                  clk_data,
    input  logic                  rst,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [15:0]           cfg_int_len,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  data_out_valid,
    output logic [CHAN_W-1:0]     data_out_chan,
    output logic                  data_out_last,
    output logic                  ovf_sticky
);

    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);

    logic [CHAN_W-1:0]    chan_cnt_q, chan_cnt_d;
    logic [15:0]          spec_cnt_q, spec_cnt_d;
    logic [15:0]          int_len_cur_q, int_len_cur_d;
    logic                 load_pend_q, load_pend_d;
    logic [ACC_WIDTH-1:0] data_out_q, data_out_d;
    logic                 data_out_valid_q, data_out_valid_d;
    logic [CHAN_W-1:0]    data_out_chan_q, data_out_chan_d;
    logic                 data_out_last_q, data_out_last_d;
    logic                 ovf_sticky_q, ovf_sticky_d;

    logic [ACC_WIDTH-1:0] ram_q [NUM_CHAN];

    logic [15:0]          cfg_len_clamped;
    logic [15:0]          int_len_eff;
    logic                 last_spec;
    logic                 first_spec;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] data_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf_hit;
`ifdef MAG_INTEG_SAT_EN
    logic [ACC_WIDTH:0]   sum_wide;
`endif

    // Integration length: the first cycle after reset uses the freshly
    // sampled cfg value so a valid arriving on that cycle is handled correctly.
    always_comb begin
        cfg_len_clamped = (cfg_int_len == 16'd0) ? 16'd1 : cfg_int_len;
        int_len_eff     = load_pend_q ? cfg_len_clamped : int_len_cur_q;
        last_spec       = (spec_cnt_q == 16'(int_len_eff - 16'd1));
        first_spec      = (spec_cnt_q == 16'd0);
    end

    // Accumulate: the first spectrum of an integration overwrites stale RAM.
    always_comb begin
        acc_base = first_spec ? '0 : ram_q[chan_cnt_q];
        data_ext = ACC_WIDTH'(data_in);
`ifdef MAG_INTEG_SAT_EN
        sum_wide = {1'b0, acc_base} + {1'b0, data_ext};
        ovf_hit  = sum_wide[ACC_WIDTH];
        sum      = ovf_hit ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
        ovf_hit  = 1'b0;
        sum      = acc_base + data_ext;
`endif
    end

    // Channel/spectrum counters, length reload and output staging.
    always_comb begin
        chan_cnt_d       = chan_cnt_q;
        spec_cnt_d       = spec_cnt_q;
        int_len_cur_d    = int_len_eff;
        load_pend_d      = 1'b0;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        data_out_chan_d  = data_out_chan_q;
        data_out_last_d  = data_out_last_q;
        ovf_sticky_d     = ovf_sticky_q;
        if (data_in_valid) begin
            ovf_sticky_d = ovf_sticky_q | ovf_hit;
            if (last_spec) begin
                data_out_d       = sum;
                data_out_valid_d = 1'b1;
                data_out_chan_d  = chan_cnt_q;
                data_out_last_d  = (chan_cnt_q == LAST_CHAN);
            end
            if (chan_cnt_q == LAST_CHAN) begin
                chan_cnt_d = '0;
                if (last_spec) begin
                    spec_cnt_d    = 16'd0;
                    int_len_cur_d = cfg_len_clamped;
                end else begin
                    spec_cnt_d = spec_cnt_q + 16'd1;
                end
            end else begin
                chan_cnt_d = chan_cnt_q + CHAN_W'(1);
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            chan_cnt_q       <= '0;
            spec_cnt_q       <= 16'd0;
            int_len_cur_q    <= 16'd1;
            load_pend_q      <= 1'b1;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            data_out_chan_q  <= '0;
            data_out_last_q  <= 1'b0;
            ovf_sticky_q     <= 1'b0;
        end else begin
            chan_cnt_q       <= chan_cnt_d;
            spec_cnt_q       <= spec_cnt_d;
            int_len_cur_q    <= int_len_cur_d;
            load_pend_q      <= load_pend_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_chan_q  <= data_out_chan_d;
            data_out_last_q  <= data_out_last_d;
            ovf_sticky_q     <= ovf_sticky_d;
        end
    end

    // Accumulator RAM write; not cleared by reset.
    always_ff @(posedge clk_data) begin
        if (!rst && data_in_valid) begin
            ram_q[chan_cnt_q] <= sum;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign data_out_chan  = data_out_chan_q;
    assign data_out_last  = data_out_last_q;
    assign ovf_sticky     = ovf_sticky_q;

endmodule

// File: tb/tb_mag_spec_integrator.sv
// Testbench for mag_spec_integrator (NUM_CHAN=4, ACC_WIDTH=16) against a
// per-channel running-sum reference model.
module tb_mag_spec_integrator;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam longint AMAX = (64'd1 << AW) - 1;

    logic          clk_data = 1'b0;
    logic          rst = 1'b1;
    logic          data_in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [15:0]   cfg_int_len = 16'd1;
    logic [AW-1:0] data_out;
    logic          data_out_valid;
    logic [CW-1:0] data_out_chan;
    logic          data_out_last;
    logic          ovf_sticky;

    int n_vec = 0;
    int n_err = 0;
    int out_seen = 0;
    int base;

    // reference model state
    longint m_acc [NC];
    int     m_chan, m_spec, m_len;
    bit     m_pend;
    bit     e_valid, e_last, e_ovf;
    longint e_data, e_chan;

    mag_spec_integrator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CHAN(NC), .CHAN_W(CW)) dut (
        .clk_data(clk_data), .rst(rst), .data_in_valid(data_in_valid), .data_in(data_in),
        .cfg_int_len(cfg_int_len), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_chan(data_out_chan), .data_out_last(data_out_last), .ovf_sticky(ovf_sticky));

    always #5 clk_data = ~clk_data;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int c);
        return (c == 0) ? 1 : c;
    endfunction

    // One clock edge of the model: integration is a running per-channel sum
    // that restarts on the first spectrum and is reported on the last one.
    task automatic model_edge(input bit r, input bit v, input longint d, input int cfg);
        longint s;
        e_valid = 1'b0;
        if (r) begin
            m_chan = 0; m_spec = 0; m_pend = 1'b1;
            e_data = 0; e_chan = 0; e_last = 1'b0; e_ovf = 1'b0;
            return;
        end
        if (m_pend) m_len = clamp_len(cfg);
        m_pend = 1'b0;
        if (!v) return;
        s = (m_spec == 0) ? d : m_acc[m_chan] + d;
        if (s > AMAX) begin
`ifdef MAG_INTEG_SAT_EN
            s = AMAX;
            e_ovf = 1'b1;
`else
            s = s - (AMAX + 1);
`endif
        end
        m_acc[m_chan] = s;
        if (m_spec == m_len - 1) begin
            e_valid = 1'b1;
            e_data  = s;
            e_chan  = m_chan;
            e_last  = (m_chan == NC - 1);
        end
        if (m_chan == NC - 1) begin
            m_chan = 0;
            if (m_spec == m_len - 1) begin
                m_spec = 0;
                m_len  = clamp_len(cfg);
            end else begin
                m_spec++;
            end
        end else begin
            m_chan++;
        end
    endtask

    task automatic step(input bit r, input bit v, input int d);
        @(negedge clk_data);
        rst = r;
        data_in_valid = v;
        data_in = DW'(d);
        @(posedge clk_data);
        model_edge(r, v, longint'(d), int'(cfg_int_len));
        #1;
        if (data_out_valid) out_seen++;
        chk("valid", longint'(data_out_valid), longint'(e_valid));
        chk("data", longint'(data_out), e_data);
        chk("chan", longint'(data_out_chan), e_chan);
        chk("last", longint'(data_out_last), longint'(e_last));
        chk("ovf", longint'(ovf_sticky), longint'(e_ovf));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
    endtask

    task automatic spectra(input int n, input int val);
        for (int s = 0; s < n; s++)
            for (int c = 0; c < NC; c++)
                step(1'b0, 1'b1, (val < 0) ? c + 1 : val);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) m_acc[i] = 0;
        m_chan = 0; m_spec = 0; m_len = 1; m_pend = 1'b1;
        e_valid = 0; e_last = 0; e_ovf = 0; e_data = 0; e_chan = 0;

        // reset state
        do_reset();
        step(1'b0, 1'b0, 0);
        chk("rst_valid", longint'(data_out_valid), 0);
        chk("rst_data", longint'(data_out), 0);

        // cfg=3, data=chan+1 for 3 spectra: 4 outputs 3,6,9,12
        cfg_int_len = 16'd3;
        do_reset();
        base = out_seen;
        spectra(2, -1);
        chk("p1_early_outs", longint'(out_seen - base), 0);
        spectra(1, -1);
        chk("p1_outs", longint'(out_seen - base), 4);
        chk("p1_final_data", longint'(data_out), 12);
        chk("p1_final_last", longint'(data_out_last), 1);

        // cfg=0 and cfg=1: pass-through
        cfg_int_len = 16'd0;
        do_reset();
        base = out_seen;
        spectra(2, 16'h00AB);
        chk("len0_outs", longint'(out_seen - base), 2 * NC);
        chk("len0_data", longint'(data_out), 16'h00AB);
        cfg_int_len = 16'd1;
        do_reset();
        spectra(2, 16'h00AB);

        // random gaps, cfg=2
        cfg_int_len = 16'd2;
        do_reset();
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 16'h3FFF)));

        // reset mid-spectrum 2 at channel 2
        do_reset();
        spectra(1, 1000);
        step(1'b0, 1'b1, 1000);
        step(1'b0, 1'b1, 1000);
        step(1'b1, 1'b0, 0);
        chk("midrst_valid", longint'(data_out_valid), 0);
        spectra(2, 7);
        chk("midrst_data", longint'(data_out), 14);

        // cfg change 2 -> 4 during spectrum 1
        cfg_int_len = 16'd2;
        do_reset();
        base = out_seen;
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b1, 6);
        cfg_int_len = 16'd4;
        step(1'b0, 1'b1, 7);
        step(1'b0, 1'b1, 8);
        spectra(1, -1);
        chk("cfgchg_first", longint'(out_seen - base), NC);
        spectra(3, -1);
        chk("cfgchg_mid", longint'(out_seen - base), NC);
        spectra(1, -1);
        chk("cfgchg_second", longint'(out_seen - base), 2 * NC);

        // overflow with 0xFFFF, cfg=2
        cfg_int_len = 16'd2;
        do_reset();
        spectra(2, 16'hFFFF);
`ifdef MAG_INTEG_SAT_EN
        chk("ovf_data", longint'(data_out), 16'hFFFF);
        chk("ovf_flag", longint'(ovf_sticky), 1);
`else
        chk("ovf_data", longint'(data_out), 16'hFFFE);
        chk("ovf_flag", longint'(ovf_sticky), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mag_spec_integrator.md
Name: mag_spec_integrator

Overview:
- Downstream of the complex-magnitude stage: consumes its per-channel magnitude stream (one sample per valid, channels in ascending order, NUM_CHAN channels per spectrum).
- Integrates cfg_int_len consecutive spectra per channel in a channel-indexed accumulator RAM.
- Emits one integrated spectrum per integration period to the FRB detection logic.

Parameters:
- DATA_WIDTH, 16, input magnitude width (unsigned).
- ACC_WIDTH, 32, accumulator and output width; must be >= DATA_WIDTH.
- NUM_CHAN, 256, channels per spectrum; must be >= 2.
- CHAN_W, 8, channel index width; must satisfy 2^CHAN_W >= NUM_CHAN.

Ports:
- clk_data  in  1  data clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in_valid  in  1  qualifies data_in; gaps allowed at any point.
- data_in  in  DATA_WIDTH  unsigned magnitude for the current channel.
- cfg_int_len  in  16  spectra per integration; sampled only at integration start; 0 is treated as 1.
- data_out  out  ACC_WIDTH  integrated value for data_out_chan.
- data_out_valid  out  1  one-cycle qualifier for data_out.
- data_out_chan  out  CHAN_W  channel index of data_out.
- data_out_last  out  1  high with the valid for channel NUM_CHAN-1.
- ovf_sticky  out  1  accumulator-overflow flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; chan_cnt = 0, spec_cnt = 0; int_len_cur loads max(cfg_int_len, 1) on the first cycle after rst deasserts. RAM is not cleared.
- chan_cnt advances only on data_in_valid and wraps NUM_CHAN-1 -> 0.
- On that wrap, spec_cnt increments. When spec_cnt == int_len_cur-1, spec_cnt returns to 0 and int_len_cur reloads from cfg_int_len, with 0 -> 1.
- Accumulate: sum = (spec_cnt == 0) ? zero-extended data_in : ram[chan_cnt] + data_in, at ACC_WIDTH bits. Sum is written to ram[chan_cnt] on the same edge.
- Output: when spec_cnt == int_len_cur-1 and data_in_valid, the following edge registers data_out = sum, data_out_chan = chan_cnt, data_out_last = (chan_cnt == NUM_CHAN-1), data_out_valid = 1.
- Latency: exactly 1 cycle from input valid to output valid. No valid out otherwise; data_out/chan/last hold their last values when valid is 0.
- The RAM read is asynchronous (register array). Because NUM_CHAN >= 2, consecutive valids never touch the same address, so there is no read/write hazard.
- int_len_cur == 1: every spectrum is output unmodified (sum = data_in).
- A cfg_int_len change mid-integration has no effect until the next integration start.
- rst mid-spectrum: counters zero and data_out_valid drops the next cycle. The next valid is channel 0 of a fresh integration, and stale RAM is ignored because spec_cnt == 0 overwrites it.
- No backpressure: the consumer must accept every valid.

Optional Feature:
- Macro MAG_INTEG_SAT_EN.
- Defined: the add is computed at ACC_WIDTH+1 bits. On carry-out, the result clamps to all-ones, the clamped value is stored and output, and ovf_sticky sets. ovf_sticky clears only on rst.
- Undefined: the add wraps modulo 2^ACC_WIDTH and ovf_sticky is tied 0.

Test Plan:
- NUM_CHAN=4, cfg_int_len=3, data_in=chan+1 continuous for 3 spectra -> exactly 4 outputs during spectrum 3: chan 0..3 with data_out 3,6,9,12; data_out_last only on chan 3; each 1 cycle after its input.
- cfg_int_len=0 and 1, data_in=0x00AB -> every spectrum passes through, data_out=0x00AB on each channel.
- Random 0/1 gaps on data_in_valid, cfg_int_len=2 -> outputs match a reference model; latency always 1 cycle; no output on idle cycles.
- Assert rst for 1 cycle while mid-spectrum 2 at chan 2 with nonzero RAM -> outputs 0 the next cycle; next integration results exclude pre-reset data.
- Change cfg_int_len 2 -> 4 during spectrum 1 -> the current integration still outputs after 2 spectra; the next integration outputs after 4.
- ACC_WIDTH=16, data_in=0xFFFF, cfg_int_len=2 -> with MAG_INTEG_SAT_EN: data_out=0xFFFF and ovf_sticky=1. Without it: data_out=0xFFFE and ovf_sticky=0.
